sync_bit_deglitch_edge: RTL and testbench

- Destination-domain stage that directly consumes the output of the one-bit synchronizer.
- Re-registers the synchronized bit and glitch-filters it: a level is accepted only after it has been stable for a programmable number of enabled cycles.
- Emits single-cycle rise/fall pulses and keeps a wrapping edge counter with a sticky wrap flag.
- Runs entirely on the destination clock, so the rest of the destination logic never sees metastability residue or runt pulses.

---
 rtl/sync_bit_deglitch_edge.sv | 97 +++++++++
 tb/tb_sync_bit_deglitch_edge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_bit_deglitch_edge.sv
// sync_bit_deglitch_edge
// Destination-domain stage placed after a one-bit synchronizer. It
// re-registers the synchronized bit, accepts a new level only after it has
// been stable for STABLE_CYCLES enabled cycles, emits one-cycle rise/fall
// pulses, and counts accepted edges with a sticky wrap flag.
// All outputs come straight from registers.
module sync_bit_deglitch_edge #(
  parameter logic init          = 1'b0,
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_WIDTH     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 D_IN,
  input  logic                 COUNT_CLR,
  output logic                 D_OUT,
  output logic                 RISE,
  output logic                 FALL,
  output logic [CNT_WIDTH-1:0] EDGE_COUNT,
  output logic                 COUNT_WRAP
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0]      STAB_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  logic                 r_d_q;
  logic                 r_d_out;
  logic [SC_W-1:0]      r_stab;
  logic                 r_rise;
  logic                 r_fall;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_wrap;

  logic                 w_mismatch;
  logic                 w_accept;
  logic [SC_W-1:0]      w_stab_nxt;

  // Decide whether this cycle completes the stability window, and the next count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_stab_nxt = r_stab;
    w_mismatch = (r_d_q != r_d_out);
    w_accept   = w_mismatch && EN && (r_stab == STAB_LAST);
    if (!w_mismatch) begin
      // Any return to the accepted level restarts the window, enabled or not.
      w_stab_nxt = '0;
    end else if (EN) begin
      w_stab_nxt = w_accept ? '0 : r_stab + SC_W'(1);
    end
  end

  // Input register, stability counter, filtered level and edge pulses.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST) begin
      r_d_q   <= init;
      r_d_out <= init;
      r_stab  <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_d_q  <= D_IN;
      r_stab <= w_stab_nxt;
      r_rise <= w_accept && r_d_q;
      r_fall <= w_accept && !r_d_q;
      if (w_accept) begin
        r_d_out <= r_d_q;
      end
    end
  end

  // Edge counter with sticky wrap; a clear coinciding with an edge keeps that edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (COUNT_CLR) begin
      r_cnt  <= w_accept ? CNT_ONE : '0;
      r_wrap <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_ONE;
      if (r_cnt == CNT_MAX) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign D_OUT      = r_d_out;
  assign RISE       = r_rise;
  assign FALL       = r_fall;
  assign EDGE_COUNT = r_cnt;
  assign COUNT_WRAP = r_wrap;

endmodule

// File: tb/tb_sync_bit_deglitch_edge.sv
// Testbench for sync_bit_deglitch_edge. Two instances share the stimulus:
// inst a (init=0, STABLE_CYCLES=4, CNT_WIDTH=3) and inst b (init=1,
// STABLE_CYCLES=1, CNT_WIDTH=2). A reference model scores every cycle;
// directed steps add literal checks taken from the expected behaviour.
module tb_sync_bit_deglitch_edge;

  localparam int S_A = 4;
  localparam int W_A = 3;
  localparam int S_B = 1;
  localparam int W_B = 2;

  logic CLK;
  logic RST;
  logic EN;
  logic D_IN;
  logic COUNT_CLR;

  logic           a_d_out, a_rise, a_fall, a_wrap;
  logic [W_A-1:0] a_cnt;
  logic           b_d_out, b_rise, b_fall, b_wrap;
  logic [W_B-1:0] b_cnt;

  int total_n = 0;
  int bad_n   = 0;

  sync_bit_deglitch_edge #(.init(1'b0), .STABLE_CYCLES(S_A), .CNT_WIDTH(W_A)) u_dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(D_IN), .COUNT_CLR(COUNT_CLR),
    .D_OUT(a_d_out), .RISE(a_rise), .FALL(a_fall),
    .EDGE_COUNT(a_cnt), .COUNT_WRAP(a_wrap)
  );

  sync_bit_deglitch_edge #(.init(1'b1), .STABLE_CYCLES(S_B), .CNT_WIDTH(W_B)) u_dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(D_IN), .COUNT_CLR(COUNT_CLR),
    .D_OUT(b_d_out), .RISE(b_rise), .FALL(b_fall),
    .EDGE_COUNT(b_cnt), .COUNT_WRAP(b_wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state, per instance. The filter is modelled as "the
  // number of enabled cycles since the current mismatch run began", counted
  // from a history of EN values; the edge counter as a plain running total
  // since the last clear, from which count and wrap are derived.
  int s_p[2];
  int w_p[2];
  bit init_p[2];
  bit m_dq[2];
  bit m_out[2];
  bit m_rise[2];
  bit m_fall[2];
  int m_total[2];
  int m_run[2];
  bit en_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit en, input bit din, input bit clr);
    int  t;
    int  n;
    bit  edge_now;
    t = en_hist.size() - 1;
    if (!rst) begin
      m_dq[k]    = init_p[k];
      m_out[k]   = init_p[k];
      m_rise[k]  = 1'b0;
      m_fall[k]  = 1'b0;
      m_total[k] = 0;
      m_run[k]   = -1;
      return;
    end
    edge_now  = 1'b0;
    m_rise[k] = 1'b0;
    m_fall[k] = 1'b0;
    if (m_dq[k] != m_out[k]) begin
      if (m_run[k] < 0) m_run[k] = t;
      n = 0;
      for (int i = m_run[k]; i <= t; i++) n += int'(en_hist[i]);
      if (en && n == s_p[k]) begin
        m_out[k]  = m_dq[k];
        m_rise[k] = m_dq[k];
        m_fall[k] = !m_dq[k];
        edge_now  = 1'b1;
        m_run[k]  = -1;
      end
    end else begin
      m_run[k] = -1;
    end
    if (clr) m_total[k] = edge_now ? 1 : 0;
    else     m_total[k] = m_total[k] + int'(edge_now);
    m_dq[k] = din;
  endtask

  task automatic compare_all();
    check("a.d_out", 32'(a_d_out), 32'(m_out[0]));
    check("a.rise",  32'(a_rise),  32'(m_rise[0]));
    check("a.fall",  32'(a_fall),  32'(m_fall[0]));
    check("a.count", 32'(a_cnt),   32'(m_total[0] % (1 << w_p[0])));
    check("a.wrap",  32'(a_wrap),  32'(m_total[0] >= (1 << w_p[0])));
    check("b.d_out", 32'(b_d_out), 32'(m_out[1]));
    check("b.rise",  32'(b_rise),  32'(m_rise[1]));
    check("b.fall",  32'(b_fall),  32'(m_fall[1]));
    check("b.count", 32'(b_cnt),   32'(m_total[1] % (1 << w_p[1])));
    check("b.wrap",  32'(b_wrap),  32'(m_total[1] >= (1 << w_p[1])));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic cyc(input bit rst, input bit en, input bit din, input bit clr);
    RST       = rst;
    EN        = en;
    D_IN      = din;
    COUNT_CLR = clr;
    @(posedge CLK);
    en_hist.push_back(en);
    model_step(0, rst, en, din, clr);
    model_step(1, rst, en, din, clr);
    #1;
    compare_all();
  endtask

  initial begin
    int rise_at;
    int rises;
    int hold;
    bit din_r;
    bit en_r;
    bit clr_r;
    bit rst_r;
    bit pattern[7];

    s_p[0] = S_A; w_p[0] = W_A; init_p[0] = 1'b0;
    s_p[1] = S_B; w_p[1] = W_B; init_p[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_dq[k] = init_p[k]; m_out[k] = init_p[k];
      m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_total[k] = 0; m_run[k] = -1;
    end
    RST = 1'b0; EN = 1'b0; D_IN = 1'b0; COUNT_CLR = 1'b0;

    // Reset held 3 cycles with D_IN=0: filtered levels sit at init.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst.a_d_out", 32'(a_d_out), 32'd0);
    check("rst.b_d_out", 32'(b_d_out), 32'd1);
    check("rst.b_pulses", 32'({b_rise, b_fall}), 32'd0);
    check("rst.b_count", 32'({b_wrap, b_cnt}), 32'd0);

    // Release with D_IN=0: inst b (STABLE_CYCLES=1) falls one cycle after d_q loads.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("rel.b_no_fall_yet", 32'(b_fall), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("rel.b_fall", 32'(b_fall), 32'd1);
    check("rel.b_count", 32'(b_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // Glitch of 3 cycles on inst a never reaches D_OUT.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("glitch.a_d_out", 32'(a_d_out), 32'd0);
    check("glitch.a_count", 32'(a_cnt), 32'd0);

    // A 4-cycle-stable high: single RISE at the 4th posedge after D_IN rose.
    rise_at = -1; rises = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      if (a_rise) begin
        rises++;
        if (rise_at < 0) rise_at = i;
      end
    end
    check("filt.rise_at", 32'(rise_at), 32'd4);
    check("filt.rise_count", 32'(rises), 32'd1);
    check("filt.a_d_out", 32'(a_d_out), 32'd1);

    // Back to 0, then EN gating: 4th enabled cycle of 1,0,0,1,1,0,1 is the 7th.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rise_at = -1;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, pattern[i], 1'b1, 1'b0);
      if (a_rise && rise_at < 0) rise_at = i;
    end
    check("engate.rise_at", 32'(rise_at), 32'd6);

    // Clear alone, then 8 slow toggles: 3-bit count returns to 0 with wrap set.
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr.a_count", 32'({a_wrap, a_cnt}), 32'd0);
    din_r = 1'b1;
    for (int e = 0; e < 8; e++) begin
      din_r = !din_r;
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, din_r, 1'b0);
    end
    check("wrap.a_count", 32'(a_cnt), 32'd0);
    check("wrap.a_wrap", 32'(a_wrap), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, din_r, 1'b0);
    check("wrap.a_sticky", 32'(a_wrap), 32'd1);

    // Clear coinciding with a RISE: the edge survives as count 1, wrap cleared.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, (i == 4));
    check("coll.a_rise", 32'(a_rise), 32'd1);
    check("coll.a_count", 32'(a_cnt), 32'd1);
    check("coll.a_wrap", 32'(a_wrap), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("coll.a_clr_alone", 32'(a_cnt), 32'd0);

    // Reset mid-filter: partial count discarded, full window needed afterwards.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rise_at = -1;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      if (a_rise && rise_at < 0) rise_at = i;
    end
    check("midrst.rise_at", 32'(rise_at), 32'd4);
    check("midrst.a_count", 32'(a_cnt), 32'd1);

    // Randomized traffic scored by the model every cycle.
    hold = 0; din_r = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        din_r = 1'($urandom_range(0, 1));
        hold  = int'($urandom_range(1, 7));
      end
      hold--;
      en_r  = ($urandom_range(0, 3) != 0);
      clr_r = ($urandom_range(0, 39) == 0);
      rst_r = ($urandom_range(0, 199) != 0);
      cyc(rst_r, en_r, din_r, clr_r);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
